// File: rtl/pwm_memoire_pkg.sv
// pwm_memoire_pkg: shared defaults, owner encoding and Avalon request bundle
// for the PWM pattern RAM arbiter.
package pwm_memoire_pkg;
   localparam int DEF_ADDR_W = 13;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 5000;
   localparam int BE_W       = DEF_DATA_W / 8;

   typedef enum logic {OWN_M0, OWN_M1} owner_t;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] address;
      logic                  read;
      logic                  write;
      logic [BE_W-1:0]       byteenable;
      logic [DEF_DATA_W-1:0] writedata;
   } av_req_t;
endpackage

// File: rtl/pwm_rr_arb2.sv
// pwm_rr_arb2: two-input same-cycle grant with round-robin or fixed priority,
// plus the last_grant register.
module pwm_rr_arb2
   import pwm_memoire_pkg::*;
#(
   parameter int PRIO_MODE = 0
) (
   input  logic clk,
   input  logic rst_ni,
   input  logic req0_i,
   input  logic req1_i,
   output logic gnt0_o,
   output logic gnt1_o
);
   owner_t last_q, last_d;

   // Reset leaves last_grant at m1 so m0 wins the first contention.
   assign gnt0_o = req0_i & (~req1_i | (PRIO_MODE != 0) | (last_q == OWN_M1));
   assign gnt1_o = req1_i & ~gnt0_o;
   assign last_d = gnt0_o ? OWN_M0 : gnt1_o ? OWN_M1 : last_q;

   always_ff @(posedge clk or negedge rst_ni)
      if (!rst_ni) last_q <= OWN_M1;
      else         last_q <= last_d;
endmodule

// File: rtl/pwm_memoire_arbiter.sv
// pwm_memoire_arbiter: shares the single-port PWM pattern RAM between two Avalon
// masters with range checking, a one-stage read return and an error counter.
module pwm_memoire_arbiter
   import pwm_memoire_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int PRIO_MODE = 0,
   parameter int ERR_W     = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   ram_address,
   output logic                ram_chipselect,
   output logic                ram_write,
   output logic [DATA_W/8-1:0] ram_byteenable,
   output logic [DATA_W-1:0]   ram_writedata,
   input  logic [DATA_W-1:0]   ram_readdata,
   output logic                ram_clken,
   output logic [ERR_W-1:0]    err_count
);
   av_req_t          m0_req, m1_req, sel;
   logic             gnt0, gnt1, any_gnt, in_range;
   logic             rd_pend_q, rd_oor_q;
   owner_t           rd_owner_q;
   logic [ERR_W-1:0] err_q, err_d;
   logic [DATA_W-1:0] rd_data;

   assign m0_req = '{m0_address, m0_read, m0_write, m0_byteenable, m0_writedata};
   assign m1_req = '{m1_address, m1_read, m1_write, m1_byteenable, m1_writedata};

   // Requests are masked during reset so nothing is granted while reset_n is low.
   pwm_rr_arb2 #(.PRIO_MODE(PRIO_MODE)) u_arb (
      .clk    (clk),
      .rst_ni (reset_n),
      .req0_i ((m0_read | m0_write) & reset_n),
      .req1_i ((m1_read | m1_write) & reset_n),
      .gnt0_o (gnt0),
      .gnt1_o (gnt1)
   );

   assign any_gnt        = gnt0 | gnt1;
   assign sel            = gnt1 ? m1_req : m0_req;
   assign in_range       = 32'(sel.address) < 32'($unsigned(DEPTH));
   assign m0_waitrequest = ~gnt0;
   assign m1_waitrequest = ~gnt1;

   assign ram_address    = sel.address;
   assign ram_byteenable = sel.byteenable;
   assign ram_writedata  = sel.writedata;
   assign ram_chipselect = any_gnt & in_range;
   assign ram_write      = any_gnt & sel.write & in_range;
   assign ram_clken      = 1'b1;

   assign err_d     = (any_gnt && !in_range && err_q != '1) ? err_q + ERR_W'(1) : err_q;
   assign err_count = err_q;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         rd_pend_q  <= 1'b0;
         rd_owner_q <= OWN_M0;
         rd_oor_q   <= 1'b0;
         err_q      <= '0;
      end else begin
         rd_pend_q  <= any_gnt & ~sel.write;
         rd_owner_q <= gnt1 ? OWN_M1 : OWN_M0;
         rd_oor_q   <= ~in_range;
         err_q      <= err_d;
      end

   assign rd_data          = rd_oor_q ? '0 : ram_readdata;
   assign m0_readdatavalid = rd_pend_q & (rd_owner_q == OWN_M0);
   assign m1_readdatavalid = rd_pend_q & (rd_owner_q == OWN_M1);
   assign m0_readdata      = m0_readdatavalid ? rd_data : '0;
   assign m1_readdata      = m1_readdatavalid ? rd_data : '0;
endmodule

// File: tb/tb_pwm_memoire_arbiter.sv
// tb_pwm_memoire_arbiter: directed vectors against a behavioural 1-cycle RAM,
// plus reset-mid-read and fixed-priority sequences.
module tb_pwm_memoire_arbiter;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic [12:0] m0_address, m1_address;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [3:0]  be;
   logic [31:0] wd;
   logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
   logic [31:0] m0_readdata, m1_readdata;
   logic [12:0] ram_address;
   logic        ram_chipselect, ram_write, ram_clken;
   logic [3:0]  ram_byteenable;
   logic [31:0] ram_writedata, ram_readdata;
   logic [15:0] err_count;
   logic        p_wait0, p_wait1, p_rdv0, p_rdv1, p_cs, p_wr, p_clken;
   logic [31:0] p_rd0, p_rd1, p_wd;
   logic [12:0] p_addr;
   logic [3:0]  p_be;
   logic [15:0] p_err;
   logic [31:0] zero32 = '0;

   logic [31:0] mem [0:8191];
   logic [12:0] ram_aq;
   logic        pl_en = 1'b0;
   logic [12:0] pl_a;
   logic [31:0] pl_d;
   int          n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pl_en) mem[pl_a] <= pl_d;
      if (ram_chipselect) begin
         ram_aq <= ram_address;
         if (ram_write)
            for (int b = 0; b < 4; b++)
               if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end
   end
   assign ram_readdata = mem[ram_aq];

   pwm_memoire_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_byteenable(be), .m0_writedata(wd), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_byteenable(be), .m1_writedata(wd), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
      .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata),
      .ram_readdata(ram_readdata), .ram_clken(ram_clken), .err_count(err_count)
   );

   pwm_memoire_arbiter #(.PRIO_MODE(1)) dut_p (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_byteenable(be), .m0_writedata(wd), .m0_waitrequest(p_wait0),
      .m0_readdata(p_rd0), .m0_readdatavalid(p_rdv0),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_byteenable(be), .m1_writedata(wd), .m1_waitrequest(p_wait1),
      .m1_readdata(p_rd1), .m1_readdatavalid(p_rdv1),
      .ram_address(p_addr), .ram_chipselect(p_cs), .ram_write(p_wr),
      .ram_byteenable(p_be), .ram_writedata(p_wd),
      .ram_readdata(zero32), .ram_clken(p_clken), .err_count(p_err)
   );

   typedef struct packed {
      logic r0, w0; logic [12:0] a0;
      logic r1, w1; logic [12:0] a1;
      logic [3:0] be; logic [31:0] wd;
      logic wait0, wait1, rdv0, rdv1;
      logic [31:0] rd0, rd1;
      logic cs; logic [15:0] err;
   } vec_t;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic drive(input logic r0, w0, input logic [12:0] a0,
                        input logic r1, w1, input logic [12:0] a1);
      m0_read = r0; m0_write = w0; m0_address = a0;
      m1_read = r1; m1_write = w1; m1_address = a1;
   endtask

   vec_t vt [17];

   initial begin
      logic [12:0] pa [6];
      logic [31:0] pd [6];
      //              r0 w0 a0     r1 w1 a1   be     wd            w0 w1 v0 v1 rd0           rd1           cs err
      vt[0]  = '{1'b1,1'b0,13'd5,   1'b0,1'b0,13'd0,  4'hF,32'h0,        1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b1,16'd0};
      vt[1]  = '{1'b0,1'b0,13'd0,   1'b0,1'b0,13'd0,  4'hF,32'h0,        1'b1,1'b1,1'b1,1'b0,32'h12345678, 32'h0,        1'b0,16'd0};
      vt[2]  = '{1'b1,1'b0,13'd0,   1'b1,1'b0,13'd10, 4'hF,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,16'd0};
      vt[3]  = '{1'b1,1'b0,13'd0,   1'b1,1'b0,13'd11, 4'hF,32'h0,        1'b0,1'b1,1'b0,1'b1,32'h0,        32'h000000B0, 1'b1,16'd0};
      vt[4]  = '{1'b1,1'b0,13'd1,   1'b1,1'b0,13'd11, 4'hF,32'h0,        1'b1,1'b0,1'b1,1'b0,32'h000000A0, 32'h0,        1'b1,16'd0};
      vt[5]  = '{1'b1,1'b0,13'd1,   1'b0,1'b0,13'd0,  4'hF,32'h0,        1'b0,1'b1,1'b0,1'b1,32'h0,        32'h000000B1, 1'b1,16'd0};
      vt[6]  = '{1'b0,1'b0,13'd0,   1'b0,1'b0,13'd0,  4'hF,32'h0,        1'b1,1'b1,1'b1,1'b0,32'h000000A1, 32'h0,        1'b0,16'd0};
      vt[7]  = '{1'b0,1'b0,13'd0,   1'b0,1'b1,13'd7,  4'h5,32'hAABBCCDD, 1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,16'd0};
      vt[8]  = '{1'b1,1'b0,13'd7,   1'b0,1'b0,13'd0,  4'hF,32'h0,        1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b1,16'd0};
      vt[9]  = '{1'b0,1'b0,13'd0,   1'b0,1'b0,13'd0,  4'hF,32'h0,        1'b1,1'b1,1'b1,1'b0,32'h00BB00DD, 32'h0,        1'b0,16'd0};
      vt[10] = '{1'b0,1'b1,13'd5000,1'b0,1'b0,13'd0,  4'hF,32'hDEADBEEF, 1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b0,16'd0};
      vt[11] = '{1'b1,1'b0,13'd8191,1'b0,1'b0,13'd0,  4'hF,32'h0,        1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b0,16'd1};
      vt[12] = '{1'b0,1'b0,13'd0,   1'b0,1'b0,13'd0,  4'hF,32'h0,        1'b1,1'b1,1'b1,1'b0,32'h0,        32'h0,        1'b0,16'd2};
      vt[13] = '{1'b1,1'b1,13'd9,   1'b0,1'b0,13'd0,  4'hF,32'h11223344, 1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b1,16'd2};
      vt[14] = '{1'b0,1'b0,13'd0,   1'b0,1'b0,13'd0,  4'hF,32'h0,        1'b1,1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b0,16'd2};
      vt[15] = '{1'b0,1'b0,13'd0,   1'b1,1'b0,13'd9,  4'hF,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,16'd2};
      vt[16] = '{1'b0,1'b0,13'd0,   1'b0,1'b0,13'd0,  4'hF,32'h0,        1'b1,1'b1,1'b0,1'b1,32'h0,        32'h11223344, 1'b0,16'd2};

      pa = '{13'd5, 13'd0, 13'd1, 13'd10, 13'd11, 13'd7};
      pd = '{32'h12345678, 32'hA0, 32'hA1, 32'hB0, 32'hB1, 32'h0};
      be = 4'hF; wd = '0;
      drive(1'b1, 1'b0, 13'd0, 1'b1, 1'b0, 13'd10);
      #1;
      for (int k = 0; k < 6; k++) begin
         pl_en = 1'b1; pl_a = pa[k]; pl_d = pd[k];
         @(posedge clk); #1;
      end
      pl_en = 1'b0;
      @(negedge clk);
      chk("rst wait0", 32'(m0_waitrequest), 32'd1);
      chk("rst wait1", 32'(m1_waitrequest), 32'd1);
      chk("rst cs", 32'(ram_chipselect), 32'd0);
      chk("rst ram_write", 32'(ram_write), 32'd0);
      chk("rst rdv0", 32'(m0_readdatavalid), 32'd0);
      chk("rst rdv1", 32'(m1_readdatavalid), 32'd0);
      chk("rst rd0", m0_readdata, 32'd0);
      chk("rst err", 32'(err_count), 32'd0);
      chk("clken", 32'(ram_clken), 32'd1);
      @(posedge clk); #1;
      reset_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         drive(vt[i].r0, vt[i].w0, vt[i].a0, vt[i].r1, vt[i].w1, vt[i].a1);
         be = vt[i].be; wd = vt[i].wd;
         @(negedge clk);
         chk($sformatf("v%0d wait0", i), 32'(m0_waitrequest), 32'(vt[i].wait0));
         chk($sformatf("v%0d wait1", i), 32'(m1_waitrequest), 32'(vt[i].wait1));
         chk($sformatf("v%0d rdv0", i), 32'(m0_readdatavalid), 32'(vt[i].rdv0));
         chk($sformatf("v%0d rdv1", i), 32'(m1_readdatavalid), 32'(vt[i].rdv1));
         chk($sformatf("v%0d rd0", i), m0_readdata, vt[i].rd0);
         chk($sformatf("v%0d rd1", i), m1_readdata, vt[i].rd1);
         chk($sformatf("v%0d cs", i), 32'(ram_chipselect), 32'(vt[i].cs));
         chk($sformatf("v%0d err", i), 32'(err_count), 32'(vt[i].err));
         @(posedge clk); #1;
      end

      // Reset arrives in the cycle after m0's read is accepted.
      be = 4'hF; wd = '0;
      drive(1'b1, 1'b0, 13'd5, 1'b0, 1'b0, 13'd0);
      @(negedge clk);
      chk("mid accept wait0", 32'(m0_waitrequest), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b0;
      drive(1'b1, 1'b0, 13'd0, 1'b1, 1'b0, 13'd10);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk($sformatf("mid rst%0d rdv0", c), 32'(m0_readdatavalid), 32'd0);
         chk($sformatf("mid rst%0d rdv1", c), 32'(m1_readdatavalid), 32'd0);
         chk($sformatf("mid rst%0d err", c), 32'(err_count), 32'd0);
         chk($sformatf("mid rst%0d wait1", c), 32'(m1_waitrequest), 32'd1);
         chk($sformatf("mid rst%0d cs", c), 32'(ram_chipselect), 32'd0);
         @(posedge clk); #1;
      end
      reset_n = 1'b1;

      // After reset m0 wins first contention; the priority copy keeps m1 out.
      for (int c = 0; c < 5; c++) begin
         drive(c < 4, 1'b0, 13'(c), 1'b1, 1'b0, 13'd10);
         @(negedge clk);
         if (c == 0) begin
            chk("post rst rdv0", 32'(m0_readdatavalid), 32'd0);
            chk("post rst rr wait0", 32'(m0_waitrequest), 32'd0);
            chk("post rst rr wait1", 32'(m1_waitrequest), 32'd1);
         end
         chk($sformatf("prio c%0d wait1", c), 32'(p_wait1), (c < 4) ? 32'd1 : 32'd0);
         chk($sformatf("prio c%0d wait0", c), 32'(p_wait0), (c < 4) ? 32'd0 : 32'd1);
         @(posedge clk); #1;
      end
      drive(1'b0, 1'b0, 13'd0, 1'b0, 1'b0, 13'd0);
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pwm_memoire_arbiter.md
Name: pwm_memoire_arbiter

Overview:
Two-master arbiter that shares the single-port 32-bit, 5000-word PWM pattern RAM between the Nios data master (m0) and the PWM table-fetch engine (m1). It presents an Avalon-MM slave with waitrequest and readdatavalid to each master. It drives one RAM port whose read latency is 1 cycle (registered address, unregistered q). It also performs address range checking and counts rejected accesses.

Parameters:
ADDR_W, 13, word address width on masters and RAM
DATA_W, 32, data width; byteenable width is DATA_W/8
DEPTH, 5000, number of valid RAM words; addresses >= DEPTH are out of range
PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority, m0 highest
ERR_W, 16, width of the error counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_W  master 0 word address
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_byteenable  in  DATA_W/8  master 0 byte lanes
m0_writedata  in  DATA_W  master 0 write data
m0_waitrequest  out  1  high = request not accepted this cycle
m0_readdata  out  DATA_W  master 0 read data
m0_readdatavalid  out  1  master 0 read data valid strobe
m1_*  same set as m0_* for master 1
ram_address  out  ADDR_W  RAM address
ram_chipselect  out  1  RAM select
ram_write  out  1  RAM write
ram_byteenable  out  DATA_W/8  RAM byte lanes
ram_writedata  out  DATA_W  RAM write data
ram_readdata  in  DATA_W  RAM q, valid 1 cycle after the address is accepted
ram_clken  out  1  constant 1
err_count  out  ERR_W  saturating count of out-of-range accesses

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n).
- Values while reset_n is low: all registered state cleared; last_grant = m1, so m0 wins the first contention. Combinational outputs follow from the cleared state: m*_readdatavalid = 0, m*_readdata = 0, err_count = 0, ram_chipselect = 0, ram_write = 0, m*_waitrequest = 1.
- Requests: req_i = mi_read | mi_write. If both are high, the access is a write and the read is dropped.
- Grant is combinational, in the same cycle as the request:
  - One requester active: it is granted.
  - Both active, PRIO_MODE = 0: the master that is not last_grant wins.
  - Both active, PRIO_MODE = 1: m0 wins.
  - The loser sees waitrequest = 1 and must hold its request stable.
- waitrequest: mi_waitrequest = ~grant_i; it is 1 when the master is idle or loses arbitration.
- last_grant updates at the clock edge whenever any grant occurs.
- RAM mux: the granted master's address, byteenable and writedata are driven onto the RAM port. ram_chipselect = grant & in_range; ram_write = granted write & in_range.
- in_range: address < DEPTH, as an unsigned compare.
- Out-of-range access: the request is still accepted (waitrequest = 0) but the RAM is not touched. err_count increments and saturates at all-ones. An out-of-range read returns 0 with normal timing.
- Read pipeline: one registered stage holds rd_pend, rd_owner and rd_oor.
  - Cycle N: read accepted.
  - Cycle N+1: mi_readdatavalid = 1 for the owner only; mi_readdata = rd_oor ? 0 : ram_readdata.
  - The non-owner's readdata is 0.
  - A new grant in cycle N+1 is allowed, giving full throughput: back-to-back reads from either master, one per cycle.
- Writes: complete in the accept cycle; there is no response.
- Read during write: at most one access per cycle exists, so a read-after-write to the same address in the next cycle returns the new data.
- Starvation: in round-robin mode, a master holding its request waits at most 1 cycle.
- Asynchronous reset mid-read: the pending readdatavalid is discarded and never issued after reset.
- ram_clken is tied to 1; the RAM's reset_req is held 0 outside this block.

Decomposition:
- Package pwm_memoire_pkg:
  - Constants: ADDR_W, DATA_W, DEPTH defaults, BE_W = DATA_W/8.
  - Enum owner_t {OWN_M0, OWN_M1}.
  - Typedef av_req_t: address, read, write, byteenable, writedata.
- One sub-module, pwm_rr_arb2: the two-input grant logic plus the last_grant register, with a PRIO_MODE parameter.
- Top level: address mux, range check, read-return pipeline and error counter.

Test Plan:
- Single read: after reset, preload RAM[5] = 0x12345678; m0 reads address 5 at cycle 0 -> m0_waitrequest = 0 at cycle 0; m0_readdatavalid = 1 with 0x12345678 at cycle 1; m1_readdatavalid stays 0.
- Contention, round-robin: both masters read continuously (m0 addresses 0,1; m1 addresses 10,11) -> grants alternate m0, m1, m0, m1; each readdatavalid lands 1 cycle after its own grant; neither master waits more than 1 cycle.
- Fixed priority (PRIO_MODE = 1): m0 requests continuously for 4 cycles while m1 requests -> m1_waitrequest = 1 for all 4 cycles; m1 is granted in cycle 4.
- Byte write: m1 writes 0xAABBCCDD with byteenable 0b0101 to address 7, which held 0; m0 reads address 7 in the next cycle -> readdata 0x00BB00DD.
- Out of range: m0 writes address 5000, then reads address 8191 -> ram_chipselect = 0 in both cycles; read returns 0 with readdatavalid; err_count = 2.
- Reset mid-read: reset_n is pulled low in the cycle after a read is accepted -> no readdatavalid during or after reset; err_count = 0; m0 wins the first contention after reset.
